vrf_wr_agu: RTL and testbench

//  Write-side address generator for the vector register file (VRF): counterpart of the read AGU.

---
 rtl/vrf_wr_agu.sv | 191 +++++++++++++++++++
 tb/tb_vrf_wr_agu.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_wr_agu.sv
// vrf_wr_agu: write-side address generator for the vector register file.
//   Takes a destination request (VR, VL, element geometry, mask enable), then
//   turns each accepted result beat into one VRF write at VR*VLMAX+beat, with
//   byte enables trimmed on the final beat and optionally ANDed with MASK_IN.
//   start_v/end_v must frame the vector exactly; a misplaced marker aborts it.
// Ports:
//   clk, rst (async, active low)
//   request:  req_valid/req_ready, VL_IN, VR_IN, elem_per_vec, bytes_per_elem, masked
//   beats:    data_valid/data_ready, data_in, start_v, end_v, MASK_IN
//   VRF:      vrf_we, vrf_addr, vrf_wdata, vrf_be
//   status:   done (vector complete), proto_err (vector aborted)
// Build option: VRF_WR_SKID_EN adds a 2-entry skid buffer on the beat input
//   with a registered data_ready.
module vrf_wr_agu #(
   parameter int unsigned VLMAX      = 32,
   parameter int unsigned ADDR_WIDTH = 31,
   parameter int unsigned VL_WIDTH   = 31,
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [VL_WIDTH:0]     VL_IN,
   input  logic [4:0]            VR_IN,
   input  logic [5:0]            elem_per_vec,
   input  logic [5:0]            bytes_per_elem,
   input  logic                  masked,
   input  logic [7:0]            MASK_IN,
   input  logic                  data_valid,
   output logic                  data_ready,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  start_v,
   input  logic                  end_v,
   output logic                  vrf_we,
   output logic [ADDR_WIDTH:0]   vrf_addr,
   output logic [DATA_WIDTH-1:0] vrf_wdata,
   output logic [7:0]            vrf_be,
   output logic                  done,
   output logic                  proto_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_DONE} state_t;

   state_t                state;
   logic [31:0]           base, beats, cnt;
   logic [7:0]            last_be;
   logic                  masked_q;

   logic [31:0]           vl32, epv_eff, beats_c, rem_c, shamt_c, base_c, addr_sum;
   logic [7:0]            last_be_c, be_c;
   logic                  k_first, k_last, b_err;

   // Beat source: either the raw input port or the skid buffer head.
   logic                  b_valid, b_start, b_end;
   logic [7:0]            b_mask;
   logic [DATA_WIDTH-1:0] b_data;

   // Request geometry, evaluated at accept time. The last-beat byte enable
   // is precomputed so the beat path only has to select it.
   always_comb begin
      vl32      = 32'(VL_IN);
      epv_eff   = (elem_per_vec == '0) ? 32'd1 : 32'(elem_per_vec);
      beats_c   = 32'((33'(vl32) + 33'(epv_eff) - 33'd1) / 33'(epv_eff));
      rem_c     = vl32 - (beats_c - 32'd1) * epv_eff;
      shamt_c   = 32'(bytes_per_elem) * (epv_eff - rem_c);
      last_be_c = (shamt_c >= 32'd8) ? '0 : (8'hFF >> shamt_c[2:0]);
      base_c    = 32'(VR_IN) * 32'(VLMAX);
   end

   always_comb begin
      k_first  = (cnt == '0);
      k_last   = (cnt == beats - 32'd1);
      b_err    = (b_start != k_first) || (b_end != k_last);
      addr_sum = base + cnt;
      be_c     = k_last ? last_be : 8'hFF;
      if (masked_q) be_c = be_c & b_mask;
   end

`ifdef VRF_WR_SKID_EN
   logic [DATA_WIDTH-1:0] sk_data [2];
   logic [7:0]            sk_mask [2];
   logic [1:0]            sk_start, sk_end, sk_cnt, sk_cnt_n;
   logic                  rd_ptr, wr_ptr, push;

   assign push     = data_valid & data_ready;
   assign b_valid  = (state == ST_WR) && (sk_cnt != 2'd0);
   assign b_data   = sk_data[rd_ptr];
   assign b_mask   = sk_mask[rd_ptr];
   assign b_start  = sk_start[rd_ptr];
   assign b_end    = sk_end[rd_ptr];
   assign sk_cnt_n = sk_cnt + {1'b0, push} - {1'b0, b_valid};

   always_ff @(posedge clk) begin
      if (push) begin
         sk_data[wr_ptr]  <= data_in;
         sk_mask[wr_ptr]  <= MASK_IN;
         sk_start[wr_ptr] <= start_v;
         sk_end[wr_ptr]   <= end_v;
      end
   end

   // Buffer is emptied whenever the vector ends (done or abort), so beats that
   // arrive after the final one never leak into the next request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sk_cnt     <= '0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         data_ready <= 1'b0;
      end else if (state != ST_WR || (b_valid && (b_err || k_last))) begin
         sk_cnt     <= '0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         data_ready <= (state == ST_IDLE) && req_valid && req_ready && (VL_IN != '0);
      end else begin
         if (push)    wr_ptr <= ~wr_ptr;
         if (b_valid) rd_ptr <= ~rd_ptr;
         sk_cnt     <= sk_cnt_n;
         data_ready <= (sk_cnt_n != 2'd2);
      end
   end
`else
   assign data_ready = (state == ST_WR);
   assign b_valid    = data_valid & data_ready;
   assign b_data     = data_in;
   assign b_mask     = MASK_IN;
   assign b_start    = start_v;
   assign b_end      = end_v;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         vrf_we    <= 1'b0;
         vrf_addr  <= '0;
         vrf_wdata <= '0;
         vrf_be    <= '0;
         done      <= 1'b0;
         proto_err <= 1'b0;
         cnt       <= '0;
         base      <= '0;
         beats     <= '0;
         last_be   <= '0;
         masked_q  <= 1'b0;
      end else begin
         vrf_we    <= 1'b0;
         done      <= 1'b0;
         proto_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  base      <= base_c;
                  beats     <= beats_c;
                  last_be   <= last_be_c;
                  masked_q  <= masked;
                  cnt       <= '0;
                  req_ready <= 1'b0;
                  state     <= (vl32 == '0) ? ST_DONE : ST_WR;
               end
            end
            ST_WR: begin
               if (b_valid) begin
                  if (b_err) begin
                     proto_err <= 1'b1;
                     cnt       <= '0;
                     req_ready <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     vrf_we    <= 1'b1;
                     vrf_addr  <= (ADDR_WIDTH+1)'(addr_sum);
                     vrf_wdata <= b_data;
                     vrf_be    <= be_c;
                     if (k_last) state <= ST_DONE;
                     else        cnt   <= cnt + 32'd1;
                  end
               end
            end
            ST_DONE: begin
               done      <= 1'b1;
               req_ready <= 1'b1;
               cnt       <= '0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vrf_wr_agu.sv
// Self-checking bench for vrf_wr_agu: directed cases, VL=0, protocol errors,
// reset mid-vector and randomized vectors against an element-level model.
module tb_vrf_wr_agu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] VL_IN = '0;
   logic [4:0]  VR_IN = '0;
   logic [5:0]  elem_per_vec = 6'd1;
   logic [5:0]  bytes_per_elem = 6'd1;
   logic        masked = 1'b0;
   logic [7:0]  MASK_IN = '0;
   logic        data_valid = 1'b0;
   logic        data_ready;
   logic [63:0] data_in = '0;
   logic        start_v = 1'b0;
   logic        end_v = 1'b0;
   logic        vrf_we;
   logic [31:0] vrf_addr;
   logic [63:0] vrf_wdata;
   logic [7:0]  vrf_be;
   logic        done;
   logic        proto_err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [31:0] obs_addr[$];
   logic [7:0]  obs_be[$];
   logic [63:0] obs_data[$];
   int          obs_cyc[$];
   int          done_cyc[$];
   int          perr_cyc[$];

   vrf_wr_agu #(.VLMAX(32), .ADDR_WIDTH(31), .VL_WIDTH(31), .DATA_WIDTH(64)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .VL_IN(VL_IN), .VR_IN(VR_IN), .elem_per_vec(elem_per_vec),
      .bytes_per_elem(bytes_per_elem), .masked(masked), .MASK_IN(MASK_IN),
      .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
      .start_v(start_v), .end_v(end_v), .vrf_we(vrf_we), .vrf_addr(vrf_addr),
      .vrf_wdata(vrf_wdata), .vrf_be(vrf_be), .done(done), .proto_err(proto_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         if (vrf_we) begin
            obs_addr.push_back(vrf_addr);
            obs_be.push_back(vrf_be);
            obs_data.push_back(vrf_wdata);
            obs_cyc.push_back(cyc);
         end
         if (done)      done_cyc.push_back(cyc);
         if (proto_err) perr_cyc.push_back(cyc);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

   task automatic clear_obs();
      obs_addr = {}; obs_be = {}; obs_data = {}; obs_cyc = {};
      done_cyc = {}; perr_cyc = {};
   endtask

   task automatic issue_request(input logic [4:0] vr, input int unsigned vl, input int unsigned epv,
                                input int unsigned bpe, input logic msk, output int rc);
      int n = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL req_ready_wait: got 0 exp 1");
      end
      req_valid = 1'b1; VR_IN = vr; VL_IN = 32'(vl);
      elem_per_vec = 6'(epv); bytes_per_elem = 6'(bpe); masked = msk;
      @(posedge clk); #1;
      rc = cyc;
      req_valid = 1'b0;
      VL_IN = 32'($urandom); VR_IN = 5'($urandom);
   endtask

   task automatic send_beat(input logic [63:0] d, input logic s, input logic e, input logic [7:0] m,
                            input int unsigned gap, output int hs);
      int n = 0;
      repeat (gap) begin @(posedge clk); #1; end
      while (!data_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!data_ready) begin
         checks++; errors++;
         $display("FAIL data_ready_wait: got 0 exp 1");
      end
      data_valid = 1'b1; data_in = d; start_v = s; end_v = e; MASK_IN = m;
      @(posedge clk); #1;
      hs = cyc;
      data_valid = 1'b0; data_in = {$urandom, $urandom};
      start_v = 1'($urandom); end_v = 1'($urandom);
   endtask

   // Drives one full vector and scores it. Expected enables come from counting,
   // per beat, the element slots that lie past VL.
   task automatic run_vector(input logic [4:0] vr, input int unsigned vl, input int unsigned epv,
                             input int unsigned bpe, input logic msk, input int unsigned gap_max,
                             input int mask_fix, input string tag);
      int unsigned beats, unused, shift;
      int          rc, hs, last_hs, n;
      logic [7:0]  m, be;
      logic [63:0] d;
      logic [31:0] e_addr[$];
      logic [7:0]  e_be[$];
      logic [63:0] e_data[$];
      int          e_cyc[$];
      clear_obs();
      beats = (vl + epv - 1) / epv;
      issue_request(vr, vl, epv, bpe, msk, rc);
      last_hs = rc;
      for (int unsigned k = 0; k < beats; k++) begin
         d = {$urandom, $urandom};
         m = (mask_fix < 0) ? 8'($urandom) : 8'(mask_fix);
         unused = 0;
         for (int unsigned e = 0; e < epv; e++) if (k * epv + e >= vl) unused++;
         shift = unused * bpe;
         be = (shift >= 8) ? 8'h00 : 8'(8'hFF >> shift);
         if (msk) be = be & m;
         send_beat(d, k == 0, k == beats - 1, m, $urandom_range(0, gap_max), hs);
         e_addr.push_back(32'(vr) * 32 + 32'(k));
         e_be.push_back(be);
         e_data.push_back(d);
         e_cyc.push_back(hs);
         last_hs = hs;
      end
      n = 0;
      while (done_cyc.size() == 0 && n < 20) begin @(posedge clk); #1; n++; end
      repeat (3) begin @(posedge clk); #1; end

      checks++;
      if (obs_addr.size() != e_addr.size()) begin
         errors++;
         $display("FAIL %s write_count: got %0d exp %0d", tag, obs_addr.size(), e_addr.size());
      end
      for (int i = 0; i < e_addr.size() && i < obs_addr.size(); i++) begin
         checks++;
         if (obs_addr[i] !== e_addr[i]) begin
            errors++; $display("FAIL %s addr[%0d]: got %0d exp %0d", tag, i, obs_addr[i], e_addr[i]);
         end
         checks++;
         if (obs_be[i] !== e_be[i]) begin
            errors++; $display("FAIL %s be[%0d]: got %h exp %h", tag, i, obs_be[i], e_be[i]);
         end
         checks++;
         if (obs_data[i] !== e_data[i]) begin
            errors++; $display("FAIL %s data[%0d]: got %h exp %h", tag, i, obs_data[i], e_data[i]);
         end
         checks++;
         if (obs_cyc[i] != e_cyc[i]) begin
            errors++; $display("FAIL %s latency[%0d]: got cyc %0d exp cyc %0d", tag, i, obs_cyc[i], e_cyc[i]);
         end
      end
      checks++;
      if (done_cyc.size() != 1) begin
         errors++; $display("FAIL %s done_count: got %0d exp 1", tag, done_cyc.size());
      end else begin
         checks++;
         if (done_cyc[0] != last_hs + 1) begin
            errors++; $display("FAIL %s done_cycle: got %0d exp %0d", tag, done_cyc[0], last_hs + 1);
         end
      end
      checks++;
      if (perr_cyc.size() != 0) begin
         errors++; $display("FAIL %s proto_err_count: got %0d exp 0", tag, perr_cyc.size());
      end
      checks++;
      if (req_ready !== 1'b1 || data_ready !== 1'b0) begin
         errors++; $display("FAIL %s idle_after: got rr=%b dr=%b exp rr=1 dr=0", tag, req_ready, data_ready);
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({req_ready, data_ready, vrf_we, done, proto_err} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: got rr=%b dr=%b we=%b done=%b perr=%b exp 1 0 0 0 0",
                  req_ready, data_ready, vrf_we, done, proto_err);
      end
      checks++;
      if (vrf_addr !== 32'd0 || vrf_wdata !== 64'd0 || vrf_be !== 8'd0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h wdata=%h be=%h exp 0 0 0", vrf_addr, vrf_wdata, vrf_be);
      end
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (req_ready !== 1'b1 || data_ready !== 1'b0) begin
         errors++; $display("FAIL reset_idle: got rr=%b dr=%b exp rr=1 dr=0", req_ready, data_ready);
      end
   endtask

   task automatic test_directed();
      run_vector(5'd3, 16, 8, 1, 1'b0, 1, -1, "vr3_vl16");
      run_vector(5'd1, 5, 2, 4, 1'b0, 1, -1, "vr1_vl5");
      run_vector(5'd7, 8, 8, 1, 1'b1, 0, 8'hA5, "masked_a5");
      run_vector(5'd31, 3, 4, 2, 1'b0, 0, -1, "vr31_partial");
      run_vector(5'd6, 1, 8, 2, 1'b0, 0, -1, "be_zero");
   endtask

   task automatic test_vl_zero();
      run_vector(5'd9, 0, 4, 1, 1'b0, 0, -1, "vl_zero");
   endtask

   task automatic test_proto_err();
      int rc, hs;
      clear_obs();
      issue_request(5'd2, 16, 8, 1, 1'b0, rc);
      send_beat(64'h1111, 1'b0, 1'b0, 8'hFF, 0, hs);
      checks++;
      if (proto_err !== 1'b1 || req_ready !== 1'b1 || data_ready !== 1'b0 || vrf_we !== 1'b0) begin
         errors++;
         $display("FAIL perr_start_flags: got perr=%b rr=%b dr=%b we=%b exp 1 1 0 0",
                  proto_err, req_ready, data_ready, vrf_we);
      end
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (obs_addr.size() != 0 || perr_cyc.size() != 1 || done_cyc.size() != 0) begin
         errors++;
         $display("FAIL perr_start_counts: got wr=%0d perr=%0d done=%0d exp 0 1 0",
                  obs_addr.size(), perr_cyc.size(), done_cyc.size());
      end

      clear_obs();
      issue_request(5'd4, 16, 8, 1, 1'b0, rc);
      send_beat(64'h2222, 1'b1, 1'b0, 8'hFF, 0, hs);
      send_beat(64'h3333, 1'b0, 1'b0, 8'hFF, 0, hs);
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (obs_addr.size() != 1 || perr_cyc.size() != 1 || done_cyc.size() != 0) begin
         errors++;
         $display("FAIL perr_end_counts: got wr=%0d perr=%0d done=%0d exp 1 1 0",
                  obs_addr.size(), perr_cyc.size(), done_cyc.size());
      end else begin
         checks++;
         if (obs_addr[0] !== 32'd128 || perr_cyc[0] != hs) begin
            errors++;
            $display("FAIL perr_end_detail: got addr=%0d perr_cyc=%0d exp 128 %0d", obs_addr[0], perr_cyc[0], hs);
         end
      end

      clear_obs();
      issue_request(5'd5, 16, 8, 1, 1'b0, rc);
      send_beat(64'h4444, 1'b1, 1'b1, 8'hFF, 0, hs);
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (obs_addr.size() != 0 || perr_cyc.size() != 1 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL perr_early_end: got wr=%0d perr=%0d rr=%b exp 0 1 1",
                  obs_addr.size(), perr_cyc.size(), req_ready);
      end
   endtask

   task automatic test_reset_mid();
      int rc, hs;
      clear_obs();
      issue_request(5'd10, 32, 8, 1, 1'b0, rc);
      send_beat(64'h5555, 1'b1, 1'b0, 8'hFF, 0, hs);
      checks++;
      if (vrf_we !== 1'b1 || vrf_addr !== 32'd320) begin
         errors++; $display("FAIL mid_first_write: got we=%b addr=%0d exp 1 320", vrf_we, vrf_addr);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({req_ready, data_ready, vrf_we, done, proto_err} !== 5'b10000 ||
          vrf_addr !== 32'd0 || vrf_wdata !== 64'd0 || vrf_be !== 8'd0) begin
         errors++;
         $display("FAIL mid_async_reset: got rr=%b dr=%b we=%b done=%b perr=%b addr=%h wd=%h be=%h exp 1 0 0 0 0 0 0 0",
                  req_ready, data_ready, vrf_we, done, proto_err, vrf_addr, vrf_wdata, vrf_be);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if (done_cyc.size() != 0 || perr_cyc.size() != 0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_after: got done=%0d perr=%0d rr=%b exp 0 0 1",
                  done_cyc.size(), perr_cyc.size(), req_ready);
      end
      run_vector(5'd10, 32, 8, 1, 1'b0, 0, -1, "mid_recover");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++)
         run_vector(5'($urandom), $urandom_range(1, 40), $urandom_range(1, 8),
                    1 << $urandom_range(0, 3), 1'($urandom), 0, -1, "b2b");
   endtask

   task automatic test_random();
      for (int i = 0; i < 15; i++)
         run_vector(5'($urandom), $urandom_range(1, 40), $urandom_range(1, 8),
                    1 << $urandom_range(0, 3), 1'($urandom), 3, -1, "random");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_vl_zero();
      test_proto_err();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
